// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MULT = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_MULT = S_MULT,
        ST_DIV  = S_DIV,
        ST_FIX  = S_FIX,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Control <-> mult/div request/result bundle. Optional i_Unsigned exists only
// when MULDIV_UNSIGNED_EN is defined.
interface muldiv_if #(
    parameter int WIDTH = muldiv_pkg::WIDTH_DEFAULT
);
    logic             i_Start;
    logic             i_Op;
    logic [WIDTH-1:0] i_A;
    logic [WIDTH-1:0] i_B;
`ifdef MULDIV_UNSIGNED_EN
    logic             i_Unsigned;
`endif
    logic             o_Busy;
    logic             o_Done;
    logic             o_DivZero;
    logic [WIDTH-1:0] o_Hi;
    logic [WIDTH-1:0] o_Lo;

    modport master (
`ifdef MULDIV_UNSIGNED_EN
        output i_Unsigned,
`endif
        output i_Start, i_Op, i_A, i_B,
        input  o_Busy, o_Done, o_DivZero, o_Hi, o_Lo
    );

    modport slave (
`ifdef MULDIV_UNSIGNED_EN
        input  i_Unsigned,
`endif
        input  i_Start, i_Op, i_A, i_B,
        output o_Busy, o_Done, o_DivZero, o_Hi, o_Lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {acc, q} pair: shift-add for mult, restoring
// shift-subtract for div. Purely combinational.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [2*WIDTH-1:0] i_acc_q,
    input  logic [WIDTH-1:0]   i_opnd,
    input  logic               i_op,
    output logic [2*WIDTH-1:0] o_acc_q
);

    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem;
    logic [WIDTH-1:0] w_diff;

    assign w_acc = i_acc_q[2*WIDTH-1:WIDTH];
    assign w_q   = i_acc_q[WIDTH-1:0];

    // The shifted remainder can reach 2*divisor, so it needs one extra bit.
    assign w_sum  = {1'b0, w_acc} + (w_q[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
    assign w_rem  = {w_acc, w_q[WIDTH-1]};
    assign w_diff = w_rem[WIDTH-1:0] - i_opnd;

    always_comb begin
        // NOTE: default first so every path assigns o_acc_q and no latch is inferred.
        o_acc_q = '0;
        if (i_op == OP_MULT) begin
            o_acc_q = {w_sum, w_q[WIDTH-1:1]};
        end else if (w_rem >= {1'b0, i_opnd}) begin
            o_acc_q = {w_diff, w_q[WIDTH-2:0], 1'b1};
        end else begin
            o_acc_q = {w_rem[WIDTH-1:0], w_q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed mult/div with HI/LO registers, one radix-2 step per cycle.
// Defining MULDIV_UNSIGNED_EN adds i_Unsigned for multu/divu.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic    Clock,
    input  logic    Reset,
    muldiv_if.slave io_bus
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_unsigned;
    logic               w_accept;
    logic               w_iterating;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

`ifdef MULDIV_UNSIGNED_EN
    assign w_unsigned = io_bus.i_Unsigned;
`else
    assign w_unsigned = 1'b0;
`endif

    assign w_accept    = (r_state == ST_IDLE) && io_bus.i_Start;
    assign w_iterating = (r_state == ST_MULT) || (r_state == ST_DIV);

    // Forcing the signs to zero for unsigned ops bypasses both the magnitude
    // latch and the FIX negation without touching the iteration path.
    assign w_sign_a = ~w_unsigned & io_bus.i_A[WIDTH-1];
    assign w_sign_b = ~w_unsigned & io_bus.i_B[WIDTH-1];
    assign w_mag_a  = w_sign_a ? -io_bus.i_A : io_bus.i_A;
    assign w_mag_b  = w_sign_b ? -io_bus.i_B : io_bus.i_B;

    assign w_prod = (r_sign_a ^ r_sign_b) ? -{r_acc, r_q} : {r_acc, r_q};
    assign w_quot = (r_sign_a ^ r_sign_b) ? -r_q : r_q;
    assign w_rem  = r_sign_a ? -r_acc : r_acc;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_acc_q (r_acc_q_pack()),
        .i_opnd  (r_opnd),
        .i_op    (r_op),
        .o_acc_q (w_step)
    );

    function automatic logic [2*WIDTH-1:0] r_acc_q_pack();
        return {r_acc, r_q};
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.i_Start) begin
                    if (io_bus.i_Op == OP_MULT)   w_state_nxt = ST_MULT;
                    else if (io_bus.i_B == '0)    w_state_nxt = ST_DONE;
                    else                          w_state_nxt = ST_DIV;
                end
            end
            ST_MULT, ST_DIV: if (r_cnt == CNT_LAST) w_state_nxt = ST_FIX;
            ST_FIX:          w_state_nxt = ST_DONE;
            ST_DONE:         w_state_nxt = ST_IDLE;
            default:         w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            if (w_accept) begin
                r_cnt      <= '0;
                r_div_zero <= (io_bus.i_Op == OP_DIV) && (io_bus.i_B == '0);
            end else if (w_iterating && (r_cnt != CNT_LAST)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == ST_FIX) begin
                if (r_op == OP_MULT) begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end else begin
                    r_hi <= w_rem;
                    r_lo <= w_quot;
                end
            end
        end
    end

    // NOTE: working registers are reloaded on every accepted start, so they carry no reset.
    always_ff @(posedge Clock) begin
        if (w_accept) begin
            r_op     <= io_bus.i_Op;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_acc    <= '0;
            r_opnd   <= (io_bus.i_Op == OP_MULT) ? w_mag_a : w_mag_b;
            r_q      <= (io_bus.i_Op == OP_MULT) ? w_mag_b : w_mag_a;
        end else if (w_iterating) begin
            {r_acc, r_q} <= w_step;
        end
    end

    assign io_bus.o_Busy    = (r_state != ST_IDLE);
    assign io_bus.o_Done    = (r_state == ST_DONE);
    assign io_bus.o_DivZero = r_div_zero;
    assign io_bus.o_Hi      = r_hi;
    assign io_bus.o_Lo      = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer; unsigned cases build only with MULDIV_UNSIGNED_EN.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

    typedef struct {
        string        tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic clk;
    logic rst;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .Clock  (clk),
        .Reset  (rst),
        .io_bus (bus)
    );

    exp_t         sb[$];
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    int           n_checks = 0;
    int           n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference arithmetic in 64-bit; also tracks HI/LO for the div-by-zero hold case.
    function automatic exp_t predict(input string tag, input logic op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic uns);
        exp_t        e;
        longint      sa;
        longint      sbv;
        longint      p;
        logic [63:0] up;
        e.tag = tag;
        e.dz  = 1'b0;
        sa    = $signed(a);
        sbv   = $signed(b);
        if (op == OP_MULT) begin
            if (uns) begin
                up = {32'b0, a} * {32'b0, b};
            end else begin
                p  = sa * sbv;
                up = p;
            end
            e.hi = up[63:32];
            e.lo = up[31:0];
        end else if (b == '0) begin
            e.dz = 1'b1;
            e.hi = m_hi;
            e.lo = m_lo;
        end else if (uns) begin
            e.lo = a / b;
            e.hi = a % b;
        end else begin
            p    = sa / sbv;
            e.lo = p[31:0];
            p    = sa % sbv;
            e.hi = p[31:0];
        end
        if (!e.dz) begin
            m_hi = e.hi;
            m_lo = e.lo;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.o_Done) begin
            check("done_expected", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.tag, " hi"}, bus.o_Hi, e.hi);
                check({e.tag, " lo"}, bus.o_Lo, e.lo);
                check({e.tag, " divzero"}, bus.o_DivZero, e.dz);
            end
        end
    end

    // poke = cycle number (1 = first cycle after acceptance) at which a stray start is driven.
    task automatic run_op(input string tag, input logic op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic uns, input int exp_lat, input int poke);
        int lat  = 0;
        int busy = 0;
        sb.push_back(predict(tag, op, a, b, uns));
        bus.i_Start = 1'b1;
        bus.i_Op    = op;
        bus.i_A     = a;
        bus.i_B     = b;
`ifdef MULDIV_UNSIGNED_EN
        bus.i_Unsigned = uns;
`endif
        do begin
            @(negedge clk);
            lat++;
            if (bus.o_Busy) busy++;
            bus.i_Start = (lat == poke);
            if (lat == poke) begin
                bus.i_Op = ~op;
                bus.i_A  = 32'h5;
                bus.i_B  = '0;
            end
        end while (!bus.o_Done && lat < 200);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy"}, busy, exp_lat);
        @(negedge clk);
        bus.i_Start = 1'b0;
        check({tag, " idle"}, bus.o_Busy, 1'b0);
    endtask

    task automatic reset_mid_op();
        int dones = 0;
        bus.i_Start = 1'b1;
        bus.i_Op    = OP_MULT;
        bus.i_A     = 32'd9;
        bus.i_B     = 32'd9;
        @(negedge clk);
        bus.i_Start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("midrst busy", bus.o_Busy, 1'b0);
        check("midrst hi", bus.o_Hi, m_hi);
        check("midrst lo", bus.o_Lo, m_lo);
        check("midrst done", bus.o_Done, 1'b0);
        repeat (40) begin
            @(negedge clk);
            if (bus.o_Done) dones++;
        end
        check("midrst no done", dones, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rop;
        rst         = 1'b1;
        bus.i_Start = 1'b0;
        bus.i_Op    = OP_MULT;
        bus.i_A     = '0;
        bus.i_B     = '0;
`ifdef MULDIV_UNSIGNED_EN
        bus.i_Unsigned = 1'b0;
`endif
        m_hi = '0;
        m_lo = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy", bus.o_Busy, 1'b0);
        check("reset done", bus.o_Done, 1'b0);
        check("reset divzero", bus.o_DivZero, 1'b0);
        check("reset hi", bus.o_Hi, 32'h0);
        check("reset lo", bus.o_Lo, 32'h0);

        run_op("mult 7*-3", OP_MULT, 32'd7, -32'sd3, 1'b0, 34, 0);
        run_op("div -7/2", OP_DIV, -32'sd7, 32'd2, 1'b0, 34, 0);
        run_op("div 5/0", OP_DIV, 32'd5, 32'd0, 1'b0, 1, 0);
        repeat (3) @(negedge clk);
        check("divzero hold", bus.o_DivZero, 1'b1);
        check("divzero hi hold", bus.o_Hi, m_hi);
        check("divzero lo hold", bus.o_Lo, m_lo);
        run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 34, 0);
        run_op("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 34, 0);
        run_op("mult busy poke", OP_MULT, 32'd123456, -32'sd98765, 1'b0, 34, 5);
        run_op("div busy poke", OP_DIV, 32'd1000, 32'd7, 1'b0, 34, 17);
        run_op("div done poke", OP_DIV, -32'sd1000, -32'sd7, 1'b0, 34, 34);
        run_op("div small", OP_DIV, 32'd3, -32'sd10, 1'b0, 34, 0);

        for (int i = 0; i < 6; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 1'($urandom_range(0, 1));
            if (rb == '0) rb = 32'd1;
            if (i == 5) rb = {16'h0, rb[15:0]} | 32'd1;
            run_op($sformatf("rand%0d", i), rop, ra, rb, 1'b0, 34, 0);
        end

        run_op("mult pre-reset", OP_MULT, 32'd7, -32'sd3, 1'b0, 34, 0);
        reset_mid_op();
        run_op("mult post-reset", OP_MULT, 32'd6, 32'd7, 1'b0, 34, 0);

`ifdef MULDIV_UNSIGNED_EN
        run_op("multu", OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1, 34, 0);
        run_op("divu", OP_DIV, 32'hFFFF_FFFF, 32'd2, 1'b1, 34, 0);
        run_op("divu bigdiv", OP_DIV, 32'h8000_0001, 32'hC000_0000, 1'b1, 34, 0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
